// File: rtl/dv_test_status_monitor_pkg.sv
// Shared types and signature constants for the console test-status monitor.
`timescale 1ns/1ps
package dv_test_status_monitor_pkg;

    typedef enum logic [1:0] {
        ST_LINE_START = 2'd0,
        ST_MATCH      = 2'd1,
        ST_SKIP       = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    localparam int unsigned SIG_LEN    = 18;
    localparam int unsigned PREFIX_LEN = 5;
    localparam int unsigned BRANCH_LEN = 13;

    localparam logic [8*PREFIX_LEN-1:0] PREFIX_STR = "TEST ";
    localparam logic [8*BRANCH_LEN-1:0] PASS_STR   = "PASSED CHECKS";
    localparam logic [8*BRANCH_LEN-1:0] FAIL_STR   = "FAILED CHECKS";

    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_T  = 8'h54;
    localparam logic [7:0] CHAR_P  = 8'h50;
    localparam logic [7:0] CHAR_F  = 8'h46;

    function automatic logic is_eol(input logic [7:0] c);
        return (c == CHAR_LF) || (c == CHAR_CR);
    endfunction

    // Expected byte at signature position idx (0..17); branch bytes start at PREFIX_LEN.
    function automatic logic [7:0] sig_char(input logic [4:0] idx, input logic is_fail);
        int unsigned p;
        p = 32'(idx);
        if (p < PREFIX_LEN)
            return PREFIX_STR[8*(PREFIX_LEN-1-p) +: 8];
        else if (p < SIG_LEN)
            return is_fail ? FAIL_STR[8*(SIG_LEN-1-p) +: 8] : PASS_STR[8*(SIG_LEN-1-p) +: 8];
        return 8'h00;
    endfunction

endpackage

// File: rtl/dv_test_status_monitor.sv
// Watches a console byte stream for the pass/fail signature lines and latches a
// sticky verdict, with an optional cycle timeout from reset release.
`timescale 1ns/1ps
module dv_test_status_monitor
    import dv_test_status_monitor_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       char_valid_i,
    input  logic [7:0] char_i,
    output logic       done_o,
    output logic       passed_o,
    output logic       failed_o,
    output logic       timeout_o
);

    localparam bit          TIMEOUT_EN   = (TimeoutCycles != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TimeoutCycles) - 32'd1;

    state_e      r_state;
    logic [4:0]  r_index;
    logic        r_is_fail;
    logic [31:0] r_tmo_cnt;

    logic w_eol;
    logic w_byte_ok;
    logic w_sig_done;
    logic w_timeout_hit;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_byte_ok = 1'b0;
        w_eol     = is_eol(char_i);
        if (r_index == 5'(SIG_LEN))
            w_byte_ok = w_eol;
        else if (r_index == 5'(PREFIX_LEN))
            w_byte_ok = (char_i == CHAR_P) || (char_i == CHAR_F);
        else
            w_byte_ok = (char_i == sig_char(r_index, r_is_fail));
    end

    assign w_sig_done    = (r_state == ST_MATCH) && char_valid_i &&
                           (r_index == 5'(SIG_LEN)) && w_eol;
    assign w_timeout_hit = TIMEOUT_EN && (r_state != ST_DONE) && (r_tmo_cnt == TIMEOUT_LAST);

    // NOTE: all state updates use non-blocking assignments so each register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_LINE_START;
            r_index   <= '0;
            r_is_fail <= 1'b0;
            r_tmo_cnt <= '0;
            done_o    <= 1'b0;
            passed_o  <= 1'b0;
            failed_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            if (r_state != ST_DONE && r_tmo_cnt != '1)
                r_tmo_cnt <= r_tmo_cnt + 32'd1;

            case (r_state)
                ST_LINE_START: begin
                    if (char_valid_i) begin
                        if (char_i == CHAR_T) begin
                            r_state <= ST_MATCH;
                            r_index <= 5'd1;
                        end else if (!w_eol) begin
                            r_state <= ST_SKIP;
                        end
                    end
                end
                ST_MATCH: begin
                    if (char_valid_i) begin
                        if (w_byte_ok) begin
                            if (r_index == 5'(SIG_LEN)) begin
                                r_state  <= ST_DONE;
                                done_o   <= 1'b1;
                                passed_o <= !r_is_fail;
                                failed_o <= r_is_fail;
                            end else begin
                                r_index <= r_index + 5'd1;
                                if (r_index == 5'(PREFIX_LEN))
                                    r_is_fail <= (char_i == CHAR_F);
                            end
                        end else begin
                            // A terminator mid-line restarts matching immediately.
                            r_state <= w_eol ? ST_LINE_START : ST_SKIP;
                            r_index <= '0;
                        end
                    end
                end
                ST_SKIP: begin
                    if (char_valid_i && w_eol)
                        r_state <= ST_LINE_START;
                end
                default: ;
            endcase

            // A signature completing on the timeout cycle takes priority.
            if (w_timeout_hit && !w_sig_done) begin
                r_state   <= ST_DONE;
                done_o    <= 1'b1;
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dv_test_status_monitor.sv
// Directed bench: three monitor instances (no timeout, 100, 40) share one stimulus stream.
`timescale 1ns/1ps
module tb_dv_test_status_monitor;

    logic       clk;
    logic       rst_n;
    logic       char_valid;
    logic [7:0] char_b;

    logic done0, passed0, failed0, timeout0;
    logic done1, passed1, failed1, timeout1;
    logic done2, passed2, failed2, timeout2;

    // Flag vectors ordered {done, passed, failed, timeout}.
    logic [3:0] flags0, flags100, flags40;
    assign flags0   = {done0, passed0, failed0, timeout0};
    assign flags100 = {done1, passed1, failed1, timeout1};
    assign flags40  = {done2, passed2, failed2, timeout2};

    int check_cnt = 0;
    int pass_cnt  = 0;

    dv_test_status_monitor #(.TimeoutCycles(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .char_valid_i(char_valid), .char_i(char_b),
        .done_o(done0), .passed_o(passed0), .failed_o(failed0), .timeout_o(timeout0)
    );

    dv_test_status_monitor #(.TimeoutCycles(100)) u_dut100 (
        .clk_i(clk), .rst_ni(rst_n), .char_valid_i(char_valid), .char_i(char_b),
        .done_o(done1), .passed_o(passed1), .failed_o(failed1), .timeout_o(timeout1)
    );

    dv_test_status_monitor #(.TimeoutCycles(40)) u_dut40 (
        .clk_i(clk), .rst_ni(rst_n), .char_valid_i(char_valid), .char_i(char_b),
        .done_o(done2), .passed_o(passed2), .failed_o(failed2), .timeout_o(timeout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic do_reset();
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_b     = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        char_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        char_valid = 1'b1;
        char_b     = b;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; char_valid = 1'b0; char_b = 8'h00;
        repeat (2) @(negedge clk);
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL reset_dut0: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        check_cnt++; if (flags100 !== 4'b0000) $display("FAIL reset_dut100: got %b expected %b", flags100, 4'b0000); else pass_cnt++;
        check_cnt++; if (flags40 !== 4'b0000) $display("FAIL reset_dut40: got %b expected %b", flags40, 4'b0000); else pass_cnt++;
    endtask

    task automatic test_pass_basic();
        do_reset();
        send_str("\nTEST PASSED CHECKS");
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL pass_before_term: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        send_byte(8'h0A);
        check_cnt++; if (flags0 !== 4'b1100) $display("FAIL pass_verdict: got %b expected %b", flags0, 4'b1100); else pass_cnt++;
    endtask

    task automatic test_fail_gaps();
        string s;
        s = "TEST FAILED CHECKS";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            idle(3);
        end
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL gaps_before_term: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        send_byte(8'h0D);
        check_cnt++; if (flags0 !== 4'b1010) $display("FAIL gaps_verdict: got %b expected %b", flags0, 4'b1010); else pass_cnt++;
        idle(3);
        check_cnt++; if (flags0 !== 4'b1010) $display("FAIL gaps_sticky: got %b expected %b", flags0, 4'b1010); else pass_cnt++;
    endtask

    task automatic test_ignored_lines();
        do_reset();
        send_str("xTEST PASSED CHECKS\n");
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL ignore_not_linestart: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        send_str("TEST PASXED\n");
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL ignore_pasxed: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        send_str("TEST FAILED CHECKS\n");
        check_cnt++; if (flags0 !== 4'b1010) $display("FAIL ignore_then_fail: got %b expected %b", flags0, 4'b1010); else pass_cnt++;
    endtask

    task automatic test_mismatch_edges();
        do_reset();
        send_str("TEST PASSED CHECKS \n");
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL trailing_space: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        send_str("TEST PASSED CHECKSX\n");
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL extra_byte: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        send_str("TEST XASSED CHECKS\n");
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL bad_branch: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        // A terminator mid-match restarts directly; the next line must still decode.
        send_str("TEST PA\rTEST PASSED CHECKS\r");
        check_cnt++; if (flags0 !== 4'b1100) $display("FAIL restart_after_eol: got %b expected %b", flags0, 4'b1100); else pass_cnt++;
        send_str("TEST FAILED CHECKS\n");
        check_cnt++; if (flags0 !== 4'b1100) $display("FAIL done_ignores_input: got %b expected %b", flags0, 4'b1100); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL async_reset_in_done: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        do_reset();
        idle(99);
        check_cnt++; if (flags100 !== 4'b0000) $display("FAIL timeout_cycle99: got %b expected %b", flags100, 4'b0000); else pass_cnt++;
        idle(1);
        check_cnt++; if (flags100 !== 4'b1001) $display("FAIL timeout_cycle100: got %b expected %b", flags100, 4'b1001); else pass_cnt++;
        send_str("TEST PASSED CHECKS\n");
        check_cnt++; if (flags100 !== 4'b1001) $display("FAIL timeout_then_pass: got %b expected %b", flags100, 4'b1001); else pass_cnt++;
        check_cnt++; if (flags40 !== 4'b1001) $display("FAIL timeout40_idle: got %b expected %b", flags40, 4'b1001); else pass_cnt++;
        check_cnt++; if (flags0 !== 4'b1100) $display("FAIL no_timeout_pass: got %b expected %b", flags0, 4'b1100); else pass_cnt++;
    endtask

    task automatic test_timeout_race();
        // Terminator consumed on the same edge the timeout would fire: signature wins.
        do_reset();
        idle(21);
        send_str("TEST PASSED CHECKS");
        check_cnt++; if (flags40 !== 4'b0000) $display("FAIL race_before_term: got %b expected %b", flags40, 4'b0000); else pass_cnt++;
        send_byte(8'h0A);
        check_cnt++; if (flags40 !== 4'b1100) $display("FAIL race_pass_wins: got %b expected %b", flags40, 4'b1100); else pass_cnt++;
        // One cycle later the timeout gets there first.
        do_reset();
        idle(22);
        send_str("TEST PASSED CHECKS\n");
        check_cnt++; if (flags40 !== 4'b1001) $display("FAIL late_term_timeout: got %b expected %b", flags40, 4'b1001); else pass_cnt++;
    endtask

    task automatic test_reset_mid_match();
        do_reset();
        send_str("TEST PASS");
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_str("SED CHECKS\n");
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL reset_mid_no_verdict: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
        send_str("TEST PASSED CHECKS\n");
        check_cnt++; if (flags0 !== 4'b1100) $display("FAIL reset_mid_then_pass: got %b expected %b", flags0, 4'b1100); else pass_cnt++;
    endtask

    task automatic test_no_timeout_default();
        do_reset();
        idle(300);
        check_cnt++; if (flags0 !== 4'b0000) $display("FAIL default_never_times_out: got %b expected %b", flags0, 4'b0000); else pass_cnt++;
    endtask

    initial begin
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_b     = 8'h00;
        test_reset();
        test_pass_basic();
        test_fail_gaps();
        test_ignored_lines();
        test_mismatch_edges();
        test_timeout();
        test_timeout_race();
        test_reset_mid_match();
        test_no_timeout_default();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/dv_test_status_monitor.md
DV_TEST_STATUS_MONITOR -- requirements
Module: dv_test_status_monitor

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 0, meaning the cycle limit from reset release to verdict (0 = timeout disabled; range 0..2^32-1).
REQ-002 SHALL have port clk_i  input  1  rising-edge clock.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port char_valid_i  input  1  char_i carries one console byte this cycle.
REQ-005 SHALL have port char_i  input  8  ASCII console byte.
REQ-006 SHALL have port done_o  output  1  verdict reached, sticky.
REQ-007 SHALL have port passed_o  output  1  pass signature decoded, sticky.
REQ-008 SHALL have port failed_o  output  1  fail signature decoded, sticky.
REQ-009 SHALL have port timeout_o  output  1  timeout expired before any signature, sticky.

Function
REQ-010 SHALL decode a byte stream for the line signatures "TEST PASSED CHECKS" and "TEST FAILED CHECKS" (18 chars each), each starting at line start and terminated by 0x0A or 0x0D.
REQ-011 SHALL always accept input (no backpressure); a byte is consumed when char_valid_i=1; cycles with char_valid_i=0 leave the matcher state unchanged.
REQ-012 SHALL implement FSM states LineStart, Match, Skip, Done; reset state LineStart; index counter 5 bits, reset 0.
REQ-013 LineStart: byte 'T' -> Match with index=1; 0x0A/0x0D -> stay; any other byte -> Skip.
REQ-014 Match, index 1..4: byte must equal "EST "; index 5: 'P' selects the pass branch, 'F' selects the fail branch, any other byte is a mismatch; index 6..17: byte must equal the selected branch string; index 18: byte must be 0x0A/0x0D.
REQ-015 On match, index increments by 1; any mismatch -> Skip, except a mismatching 0x0A/0x0D, which -> LineStart with index cleared.
REQ-016 Skip: 0x0A/0x0D -> LineStart; all other bytes -> stay.
REQ-017 Terminator accepted at index 18 -> Done; done_o and the branch flag (passed_o or failed_o) SHALL assert on the next clock edge, i.e. one cycle latency after the terminator byte.
REQ-018 Done: all input ignored; outputs held until reset; exactly one of passed_o/failed_o/timeout_o SHALL be 1 while done_o=1.
REQ-019 Timeout counter: 32 bits, clears on reset, increments each cycle while not Done, saturates; when TimeoutCycles!=0 and count reaches TimeoutCycles-1, the next edge -> Done with timeout_o=1.
REQ-020 Terminator acceptance and timeout in the same cycle: the signature verdict SHALL win and timeout_o SHALL stay 0.
REQ-021 A trailing space, or any extra byte before the terminator (e.g. "TEST PASSED CHECKSX"), SHALL be a mismatch.

Reset
REQ-022 Asserting rst_ni low at any time, including mid-match or in Done, SHALL asynchronously clear the FSM to LineStart and clear the index, the timeout counter and all outputs to 0.
REQ-023 The first byte after reset release SHALL be treated as line start.

Structure
REQ-024 SHALL place the FSM state enum, the signature length constant (18), the prefix string "TEST " and the branch strings "PASSED CHECKS"/"FAILED CHECKS" in a shared package dv_test_status_monitor_pkg.
REQ-025 SHALL be a single flat module; no sub-module is warranted.

Verification
REQ-026 Send "\nTEST PASSED CHECKS\n" one byte per cycle -> done_o=1, passed_o=1 one cycle after the final 0x0A; failed_o=0, timeout_o=0.
REQ-027 Send "TEST FAILED CHECKS\r" with a 3-cycle valid gap after each byte -> failed_o=1 one cycle after 0x0D; the gaps do not affect the result.
REQ-028 Send "xTEST PASSED CHECKS\n", then "TEST PASXED\n", then "TEST FAILED CHECKS\n" -> the first two lines are ignored; failed_o=1 only after the third line.
REQ-029 Set TimeoutCycles=100 and send no bytes -> timeout_o=1 and done_o=1 at cycle 100; a pass signature sent afterwards leaves passed_o=0.
REQ-030 Set TimeoutCycles=40 and time the pass terminator so it is consumed in cycle 39 -> passed_o=1, timeout_o=0.
REQ-031 Pulse rst_ni low after "TEST PASS", then send "SED CHECKS\n" -> no verdict; a subsequent full pass line -> passed_o=1.
